lcd_bus_ctrl: RTL and testbench



---
 rtl/lcd_bus_ctrl_if.sv | 29 ++
 rtl/lcd_bus_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_ctrl_if.sv
// Host request and LCD pin bundle for lcd_bus_ctrl; slave is the controller, master its environment.
// Only the low BUS_WIDTH data pins exist on the LCD side.
interface lcd_bus_ctrl_if #(
    parameter int BUS_WIDTH = 8
);
    logic [7:0]           data;
    logic                 rs;
    logic                 single_nibble;
    logic                 start;
    logic                 ready;
    logic [BUS_WIDTH-1:0] LCD_DATA_OUT;
    logic [BUS_WIDTH-1:0] LCD_DATA_IN;
    logic                 LCD_DATA_OE;
    logic                 LCD_EN;
    logic                 LCD_RW;
    logic                 LCD_RS;
    logic                 LCD_ON;
    logic                 LCD_BLON;

    modport master (
        output data, rs, single_nibble, start, LCD_DATA_IN,
        input  ready, LCD_DATA_OUT, LCD_DATA_OE, LCD_EN, LCD_RW, LCD_RS, LCD_ON, LCD_BLON
    );

    modport slave (
        input  data, rs, single_nibble, start, LCD_DATA_IN,
        output ready, LCD_DATA_OUT, LCD_DATA_OE, LCD_EN, LCD_RW, LCD_RS, LCD_ON, LCD_BLON
    );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// HD44780-class LCD write controller: one host write -> timed 8-bit or 4-bit bus cycles plus execution wait.
// Define LCD_BUSY_POLL_EN to replace the fixed execution wait with busy-flag polling (timeout N_SLOW).
module lcd_bus_ctrl #(
    parameter int CLK_FREQ_MZ   = 50,
    parameter int BUS_WIDTH     = 8,
    parameter int TAS_NS        = 40,
    parameter int PWEH_NS       = 230,
    parameter int TCYC_NS       = 500,
    parameter int EXEC_DATA_NS  = 43000,
    parameter int EXEC_INSTR_NS = 39000,
    parameter int EXEC_SLOW_NS  = 1530000,
    parameter bit BLON_VALUE    = 1'b0
) (
    input logic           clk,
    input logic           reset,
    lcd_bus_ctrl_if.slave bus
);
    function automatic int ns2cyc(input int ns);
        longint prod;
        longint n;
        prod = longint'(ns) * longint'(CLK_FREQ_MZ);
        n    = (prod + 64'sd999) / 64'sd1000;
        return (n < 64'sd1) ? 1 : int'(n);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int N_AS    = ns2cyc(TAS_NS);
    localparam int N_EN    = ns2cyc(PWEH_NS);
    localparam int N_LOW   = ns2cyc(TCYC_NS - PWEH_NS);
    localparam int N_DATA  = ns2cyc(EXEC_DATA_NS);
    localparam int N_INSTR = ns2cyc(EXEC_INSTR_NS);
    localparam int N_SLOW  = ns2cyc(EXEC_SLOW_NS);
    localparam int N_MAX   = imax(imax(imax(N_AS, N_EN), imax(N_LOW, N_DATA)), imax(N_INSTR, N_SLOW));
    localparam int CW      = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, EN_LOW, WAIT_EXEC} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [7:0]           data_q;
    logic                 rs_q, sn_q;
    logic                 second_q, second_nxt;
    logic                 load, split;
    logic [7:0]           d_src;
    logic                 rs_src;
    logic                 en_q, en_nxt, rs_pin_q, rs_pin_nxt, rw_q, rw_nxt, oe_q, oe_nxt;
    logic [BUS_WIDTH-1:0] dout_q, dout_nxt;

`ifdef LCD_BUSY_POLL_EN
    localparam int PW = (N_SLOW > 1) ? $clog2(N_SLOW) : 1;
    logic          poll_q, poll_nxt, busy_q, busy_nxt;
    logic [PW-1:0] ptmr, ptmr_nxt;

    // A busy read in 4-bit mode always takes two strobes, the second one a dummy.
    assign split = (BUS_WIDTH == 4) && !second_q && (!sn_q || poll_q);
`else
    logic [CW-1:0] exec_ld;
    logic          unused_din;

    assign unused_din = ^bus.LCD_DATA_IN;
    assign split      = (BUS_WIDTH == 4) && !second_q && !sn_q;

    // Clear (0x01) and home (0x02/0x03) are the slow instructions.
    always_comb begin
        if (rs_q)
            exec_ld = CW'(N_DATA - 1);
        else if (data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0)
            exec_ld = CW'(N_SLOW - 1);
        else
            exec_ld = CW'(N_INSTR - 1);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            sn_q     <= 1'b0;
            second_q <= 1'b0;
            en_q     <= 1'b0;
            rs_pin_q <= 1'b0;
            rw_q     <= 1'b0;
            oe_q     <= 1'b1;
            dout_q   <= '0;
`ifdef LCD_BUSY_POLL_EN
            poll_q   <= 1'b0;
            busy_q   <= 1'b0;
            ptmr     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            second_q <= second_nxt;
            en_q     <= en_nxt;
            rs_pin_q <= rs_pin_nxt;
            rw_q     <= rw_nxt;
            oe_q     <= oe_nxt;
            dout_q   <= dout_nxt;
            if (load) begin
                data_q <= bus.data;
                rs_q   <= bus.rs;
                sn_q   <= bus.single_nibble;
            end
`ifdef LCD_BUSY_POLL_EN
            poll_q   <= poll_nxt;
            busy_q   <= busy_nxt;
            ptmr     <= ptmr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        second_nxt = second_q;
        load       = 1'b0;
`ifdef LCD_BUSY_POLL_EN
        poll_nxt   = poll_q;
        busy_nxt   = busy_q;
        ptmr_nxt   = poll_q ? ptmr + PW'(1) : '0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = CW'(N_AS - 1);
                    second_nxt = 1'b0;
                    load       = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = EN_HIGH;
                    cnt_nxt   = CW'(N_EN - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            EN_HIGH: begin
`ifdef LCD_BUSY_POLL_EN
                if (poll_q && !second_q && cnt == '0)
                    busy_nxt = bus.LCD_DATA_IN[BUS_WIDTH-1];
`endif
                if (cnt == '0) begin
                    state_nxt = EN_LOW;
                    cnt_nxt   = CW'(N_LOW - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            EN_LOW: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (split) begin
                    state_nxt  = EN_HIGH;
                    cnt_nxt    = CW'(N_EN - 1);
                    second_nxt = 1'b1;
`ifdef LCD_BUSY_POLL_EN
                end else if (!poll_q || busy_q) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = CW'(N_AS - 1);
                    second_nxt = 1'b0;
                    poll_nxt   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    poll_nxt  = 1'b0;
                end
`else
                end else begin
                    state_nxt = WAIT_EXEC;
                    cnt_nxt   = exec_ld;
                end
`endif
            end
            WAIT_EXEC: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
`ifdef LCD_BUSY_POLL_EN
        if (poll_q && ptmr == PW'(N_SLOW - 1)) begin
            state_nxt  = IDLE;
            poll_nxt   = 1'b0;
            second_nxt = 1'b0;
        end
`endif
    end

    // Pins are registered from the next state so EN never glitches on state decode.
    always_comb begin
        d_src      = load ? bus.data : data_q;
        rs_src     = load ? bus.rs : rs_q;
        en_nxt     = (state_nxt == EN_HIGH);
        rs_pin_nxt = rs_src;
        rw_nxt     = 1'b0;
        oe_nxt     = 1'b1;
        dout_nxt   = second_nxt ? d_src[BUS_WIDTH-1:0] : d_src[7 -: BUS_WIDTH];
`ifdef LCD_BUSY_POLL_EN
        if (poll_nxt) begin
            rs_pin_nxt = 1'b0;
            rw_nxt     = 1'b1;
            oe_nxt     = 1'b0;
            dout_nxt   = dout_q;
        end
`endif
    end

    assign bus.ready        = (state == IDLE);
    assign bus.LCD_EN       = en_q;
    assign bus.LCD_RS       = rs_pin_q;
    assign bus.LCD_RW       = rw_q;
    assign bus.LCD_DATA_OE  = oe_q;
    assign bus.LCD_DATA_OUT = dout_q;
    assign bus.LCD_ON       = 1'b1;
    assign bus.LCD_BLON     = BLON_VALUE;
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench: an 8-bit 50 MHz controller and a 4-bit 10 MHz controller run side by side.
module tb_lcd_bus_ctrl;
    logic clk;
    logic rst_a, rst_b;
    int   n_chk;
    int   n_bad;

    lcd_bus_ctrl_if #(.BUS_WIDTH(8)) bus_a ();
    lcd_bus_ctrl_if #(.BUS_WIDTH(4)) bus_b ();

    lcd_bus_ctrl dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    lcd_bus_ctrl #(.BUS_WIDTH(4), .CLK_FREQ_MZ(10)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 50 MHz: setup 2, EN high 12, EN low 14, then the execution wait.
    task automatic txn_a(input logic [7:0] d, input logic r, input int wait_cyc, input int tot);
        int n_as, n_hi, n_rest, n_en;
        bus_a.data = d;
        bus_a.rs = r;
        bus_a.single_nibble = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("a_ready_drop", bus_a.ready, 0);
        check("a_rs", bus_a.LCD_RS, r);
        check("a_dout", bus_a.LCD_DATA_OUT, d);
        n_as = 0;
        while (!bus_a.LCD_EN && n_as < 100) begin tick(); n_as++; end
        check("a_setup", n_as, 2);
        n_hi = 0;
        while (bus_a.LCD_EN && n_hi < 100) begin tick(); n_hi++; end
        check("a_en_high", n_hi, 12);
        n_rest = 0;
        n_en = 0;
        while (!bus_a.ready && n_rest < 80000) begin
            tick();
            n_rest++;
            if (bus_a.LCD_EN) n_en++;
        end
        check("a_low_exec", n_rest, 14 + wait_cyc);
        check("a_extra_en", n_en, 0);
        check("a_total", 1 + n_as + n_hi + n_rest, tot);
        check("a_rs_hold", bus_a.LCD_RS, r);
        check("a_dout_hold", bus_a.LCD_DATA_OUT, d);
        check("a_rw", bus_a.LCD_RW, 0);
        check("a_oe", bus_a.LCD_DATA_OE, 1);
    endtask

    // 10 MHz 4-bit: setup 1, EN high 3, EN low 3; tail = EN low + wait after the last fall.
    task automatic txn_b(input logic [7:0] d, input logic r, input logic sn, input int pulses,
                         input int nib0, input int nib1, input int wait_cyc, input logic poke);
        int k, n_rise, n_high, first_rise, fall_k, seen0, seen1;
        logic prev_en;
        bus_b.data = d;
        bus_b.rs = r;
        bus_b.single_nibble = sn;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        check("b_rs", bus_b.LCD_RS, r);
        check("b_dout0", bus_b.LCD_DATA_OUT, nib0);
        k = 0; n_rise = 0; n_high = 0; first_rise = -1; fall_k = 0;
        seen0 = -1; seen1 = -1; prev_en = 1'b0;
        while (!bus_b.ready && k < 20000) begin
            bus_b.start = 1'b0;
            if (bus_b.LCD_EN) begin
                n_high++;
                if (!prev_en) begin
                    n_rise++;
                    if (n_rise == 1) begin
                        first_rise = k;
                        seen0 = bus_b.LCD_DATA_OUT;
                        if (poke) begin
                            bus_b.data = 8'h55;
                            bus_b.rs = 1'b0;
                            bus_b.start = 1'b1;
                        end
                    end
                    if (n_rise == 2) seen1 = bus_b.LCD_DATA_OUT;
                end
            end else if (prev_en) begin
                fall_k = k;
            end
            prev_en = bus_b.LCD_EN;
            tick();
            k++;
        end
        bus_b.start = 1'b0;
        check("b_first_rise", first_rise, 1);
        check("b_pulses", n_rise, pulses);
        check("b_en_cycles", n_high, 3 * pulses);
        check("b_nib0", seen0, nib0);
        if (pulses == 2) check("b_nib1", seen1, nib1);
        check("b_tail", k - fall_k, 3 + wait_cyc);
        check("b_rs_hold", bus_b.LCD_RS, r);
    endtask

    task automatic held_b();
        int k, acc, rises;
        logic was, prev;
        bus_b.data = 8'h30;
        bus_b.rs = 1'b0;
        bus_b.single_nibble = 1'b1;
        bus_b.start = 1'b1;
        k = 0; acc = 0; rises = 0; prev = 1'b0;
        while (acc < 3 && k < 5000) begin
            was = bus_b.ready;
            if (was) acc++;
            tick();
            k++;
            if (was) check("b_hold_take", bus_b.ready, 0);
            if (bus_b.LCD_EN && !prev) rises++;
            prev = bus_b.LCD_EN;
        end
        bus_b.start = 1'b0;
        while (!bus_b.ready && k < 5000) begin
            tick();
            k++;
            if (bus_b.LCD_EN && !prev) rises++;
            prev = bus_b.LCD_EN;
        end
        check("b_hold_txns", rises, 3);
        tick();
        tick();
        check("b_hold_idle", bus_b.ready, 1);
    endtask

    task automatic reset_mid_b();
        int k;
        bus_b.data = 8'h41;
        bus_b.rs = 1'b1;
        bus_b.single_nibble = 1'b0;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        k = 0;
        while (!bus_b.LCD_EN && k < 50) begin tick(); k++; end
        tick();
        check("b_pre_rst_en", bus_b.LCD_EN, 1);
        rst_b = 1'b1;
        tick();
        check("b_rst_en", bus_b.LCD_EN, 0);
        check("b_rst_ready", bus_b.ready, 1);
        check("b_rst_rs", bus_b.LCD_RS, 0);
        check("b_rst_dout", bus_b.LCD_DATA_OUT, 0);
        rst_b = 1'b0;
        tick();
        check("b_post_rst_ready", bus_b.ready, 1);
        check("b_post_rst_en", bus_b.LCD_EN, 0);
        txn_b(8'h41, 1'b1, 1'b0, 2, 4, 1, 430, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        clk = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.data = '0; bus_a.rs = 1'b0; bus_a.single_nibble = 1'b0; bus_a.start = 1'b0;
        bus_a.LCD_DATA_IN = '0;
        bus_b.data = '0; bus_b.rs = 1'b0; bus_b.single_nibble = 1'b0; bus_b.start = 1'b0;
        bus_b.LCD_DATA_IN = '0;
        tick();
        tick();
        check("rst_ready", bus_a.ready, 1);
        check("rst_en", bus_a.LCD_EN, 0);
        check("rst_rs", bus_a.LCD_RS, 0);
        check("rst_rw", bus_a.LCD_RW, 0);
        check("rst_oe", bus_a.LCD_DATA_OE, 1);
        check("rst_dout", bus_a.LCD_DATA_OUT, 0);
        check("rst_on", bus_a.LCD_ON, 1);
        check("rst_blon", bus_a.LCD_BLON, 0);
        check("rst_b_ready", bus_b.ready, 1);
        check("rst_b_dout", bus_b.LCD_DATA_OUT, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check("idle_ready", bus_a.ready, 1);
        check("idle_b_ready", bus_b.ready, 1);
        fork
            begin
                txn_a(8'h41, 1'b1, 2150, 2179);
                txn_a(8'h01, 1'b0, 76500, 76529);
                txn_a(8'h38, 1'b0, 1950, 1979);
                txn_a(8'h04, 1'b0, 1950, 1979);
            end
            begin
                txn_b(8'h41, 1'b1, 1'b0, 2, 4, 1, 430, 1'b0);
                txn_b(8'h30, 1'b0, 1'b1, 1, 3, 0, 390, 1'b0);
                txn_b(8'h03, 1'b0, 1'b0, 2, 0, 3, 15300, 1'b0);
                txn_b(8'h02, 1'b1, 1'b0, 2, 0, 2, 430, 1'b0);
                txn_b(8'h00, 1'b0, 1'b0, 2, 0, 0, 390, 1'b0);
                txn_b(8'h41, 1'b1, 1'b0, 2, 4, 1, 430, 1'b1);
                tick();
                tick();
                check("b_poke_ignored", bus_b.ready, 1);
                check("b_poke_rs", bus_b.LCD_RS, 1);
                check("b_poke_dout", bus_b.LCD_DATA_OUT, 1);
                held_b();
                reset_mid_b();
            end
        join
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
